// File: rtl/pipe_exu_mdu_pkg.sv
// Shared execute-stage types: op encoding, uop descriptor and helpers.
// MDU ops live in the upper half of the encoding so the MSB alone identifies them.
package liang;

    typedef logic [31:0] ele_t;

    typedef enum logic [4:0] {
        EXU_ADD   = 5'd0,
        EXU_SUB   = 5'd1,
        EXU_AND   = 5'd2,
        EXU_OR    = 5'd3,
        EXU_XOR   = 5'd4,
        EXU_SLL   = 5'd5,
        EXU_SRL   = 5'd6,
        EXU_SRA   = 5'd7,
        EXU_SLT   = 5'd8,
        EXU_SLTU  = 5'd9,
        EXU_MUL   = 5'd16,
        EXU_MULHU = 5'd17,
        EXU_DIV   = 5'd18,
        EXU_DIVU  = 5'd19,
        EXU_REM   = 5'd20,
        EXU_REMU  = 5'd21
    } exu_op_e;

    typedef struct packed {
        exu_op_e    fu_op;
        logic [4:0] rd;
        logic       rd_wen;
    } uop_info_t;

    localparam uop_info_t UOP_NONE = '{fu_op: EXU_ADD, rd: 5'd0, rd_wen: 1'b0};

    function automatic logic is_mdu_op(input exu_op_e op);
        logic [4:0] enc;
        enc = op;
        return enc[4];
    endfunction

endpackage

// File: rtl/pipe_exu_mdu_iter.sv
// Iterative radix-2 multiply/divide unit: one shift-add or restoring-subtract step per cycle.
// Signed divide works on magnitudes; sign and special-case fixup is applied on the result path.
module pipe_exu_mdu_iter
    import liang::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  exu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic              busy_r;
    logic [CW-1:0]     cnt_r;
    exu_op_e           op_r;
    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   b_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   dvd_r;
    logic              neg_q_r;
    logic              neg_rem_r;
    logic              div_zero_r;
    logic              ovf_r;

    logic              sgn_s;
    logic              is_mul_s;
    logic [XLEN-1:0]   a_mag_s;
    logic [XLEN-1:0]   b_mag_s;
    logic [XLEN:0]     mul_sum_s;
    logic [XLEN:0]     part_s;
    logic [XLEN:0]     diff_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Operand conditioning for the op being started
    always_comb begin
        sgn_s = (op == EXU_DIV) || (op == EXU_REM);
        if (sgn_s && a[XLEN-1]) a_mag_s = ZERO - a;
        else                    a_mag_s = a;
        if (sgn_s && b[XLEN-1]) b_mag_s = ZERO - b;
        else                    b_mag_s = b;
    end

    // Step datapath: acc high half accumulates the product, low half holds multiplier or quotient
    always_comb begin
        is_mul_s = (op_r == EXU_MUL) || (op_r == EXU_MULHU);
        if (acc_r[0]) mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]} + {1'b0, b_r};
        else          mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]};
        part_s = {rem_r, acc_r[XLEN-1]};
        diff_s = part_s - {1'b0, b_r};
    end

    // Iteration state: latch on start, step while busy, abandon on flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            op_r       <= EXU_ADD;
            acc_r      <= {(2*XLEN){1'b0}};
            b_r        <= ZERO;
            rem_r      <= ZERO;
            dvd_r      <= ZERO;
            neg_q_r    <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else if (flush) begin
            busy_r <= 1'b0;
            cnt_r  <= {CW{1'b0}};
        end else if (start) begin
            busy_r     <= 1'b1;
            cnt_r      <= {CW{1'b0}};
            op_r       <= op;
            acc_r      <= {ZERO, a_mag_s};
            b_r        <= b_mag_s;
            rem_r      <= ZERO;
            dvd_r      <= a;
            neg_q_r    <= sgn_s && (a[XLEN-1] ^ b[XLEN-1]);
            neg_rem_r  <= sgn_s && a[XLEN-1];
            div_zero_r <= (b == ZERO);
            ovf_r      <= sgn_s && (a == MIN_NEG) && (b == ONES);
        end else if (busy_r) begin
            cnt_r <= cnt_r + 1'b1;
            if (cnt_r == CNT_LAST) busy_r <= 1'b0;
            if (is_mul_s) begin
                acc_r <= {mul_sum_s, acc_r[XLEN-1:1]};
            end else if (!diff_s[XLEN]) begin
                rem_r <= diff_s[XLEN-1:0];
                acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], 1'b1};
            end else begin
                rem_r <= part_s[XLEN-1:0];
                acc_r <= {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], 1'b0};
            end
        end
    end

    assign done = busy_r && (cnt_r == CNT_LAST);

    // Result selection with sign restoration and divide special cases
    always_comb begin
        if (neg_q_r)   quo_s = ZERO - acc_r[XLEN-1:0];
        else           quo_s = acc_r[XLEN-1:0];
        if (neg_rem_r) rem_s = ZERO - rem_r;
        else           rem_s = rem_r;
        case (op_r)
            EXU_MUL:   result = acc_r[XLEN-1:0];
            EXU_MULHU: result = acc_r[2*XLEN-1:XLEN];
            EXU_DIV, EXU_DIVU: begin
                if (div_zero_r) result = ONES;
                else if (ovf_r) result = dvd_r;
                else            result = quo_s;
            end
            EXU_REM, EXU_REMU: begin
                if (div_zero_r) result = dvd_r;
                else if (ovf_r) result = ZERO;
                else            result = rem_s;
            end
            default:   result = ZERO;
        endcase
    end

endmodule

// File: rtl/pipe_exu_mdu.sv
// Execute stage: single-cycle ALU plus optional iterative MDU behind an IDLE/BUSY/DONE FSM,
// with valid/ready handshakes towards ID and WB and a registered output.
module pipe_exu_mdu
    import liang::*;
#(
    parameter int XLEN   = 32,
    parameter int MDU_EN = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  uop_info_t       uop_info_i,
    input  logic [XLEN-1:0] rs1_rdata_i,
    input  logic [XLEN-1:0] rs2_rdata_i,
    input  logic            id_valid_i,
    output logic            ex_ready_o,
    output uop_info_t       uop_info_o,
    output logic [XLEN-1:0] exu_output_o,
    output logic            ex_valid_o,
    input  logic            wb_ready_i
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]      state_r;
    logic            ex_valid_r;
    logic [XLEN-1:0] out_r;
    uop_info_t       uop_out_r;
    uop_info_t       uop_lat_r;

    logic            out_free_s;
    logic            accept_s;
    logic            mdu_op_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] alu_res_s;
    logic            mdu_done_s;
    logic [XLEN-1:0] mdu_result_s;

    assign out_free_s   = !ex_valid_r || wb_ready_i;
    assign ex_ready_o   = (state_r == IDLE) && !flush_i && out_free_s;
    assign accept_s     = id_valid_i && ex_ready_o;
    assign mdu_op_s     = (MDU_EN != 0) && is_mdu_op(uop_info_i.fu_op);
    assign shamt_s      = rs2_rdata_i[SHW-1:0];
    assign ex_valid_o   = ex_valid_r;
    assign exu_output_o = out_r;
    assign uop_info_o   = uop_out_r;

    // Single-cycle ALU; MDU encodings fall to zero when the unit is absent
    always_comb begin
        case (uop_info_i.fu_op)
            EXU_ADD:  alu_res_s = rs1_rdata_i + rs2_rdata_i;
            EXU_SUB:  alu_res_s = rs1_rdata_i - rs2_rdata_i;
            EXU_AND:  alu_res_s = rs1_rdata_i & rs2_rdata_i;
            EXU_OR:   alu_res_s = rs1_rdata_i | rs2_rdata_i;
            EXU_XOR:  alu_res_s = rs1_rdata_i ^ rs2_rdata_i;
            EXU_SLL:  alu_res_s = rs1_rdata_i << shamt_s;
            EXU_SRL:  alu_res_s = rs1_rdata_i >> shamt_s;
            EXU_SRA:  alu_res_s = $unsigned($signed(rs1_rdata_i) >>> shamt_s);
            EXU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, $signed(rs1_rdata_i) < $signed(rs2_rdata_i)};
            EXU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, rs1_rdata_i < rs2_rdata_i};
            default:  alu_res_s = {XLEN{1'b0}};
        endcase
    end

    generate
        if (MDU_EN != 0) begin : g_mdu
            pipe_exu_mdu_iter #(.XLEN(XLEN)) u_iter (
                .clk    (clk_i),
                .rst    (rst_i),
                .start  (accept_s && mdu_op_s),
                .op     (uop_info_i.fu_op),
                .a      (rs1_rdata_i),
                .b      (rs2_rdata_i),
                .flush  (flush_i),
                .done   (mdu_done_s),
                .result (mdu_result_s)
            );
        end else begin : g_no_mdu
            assign mdu_done_s   = 1'b0;
            assign mdu_result_s = {XLEN{1'b0}};
        end
    endgenerate

    // Stage FSM and output register; flush outranks both accept and WB transfer
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r    <= IDLE;
            ex_valid_r <= 1'b0;
            out_r      <= {XLEN{1'b0}};
            uop_out_r  <= UOP_NONE;
            uop_lat_r  <= UOP_NONE;
        end else if (flush_i) begin
            state_r    <= IDLE;
            ex_valid_r <= 1'b0;
        end else begin
            if (ex_valid_r && wb_ready_i) ex_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s && !mdu_op_s) begin
                        ex_valid_r <= 1'b1;
                        out_r      <= alu_res_s;
                        uop_out_r  <= uop_info_i;
                    end else if (accept_s) begin
                        state_r   <= BUSY;
                        uop_lat_r <= uop_info_i;
                    end
                end
                BUSY: begin
                    if (mdu_done_s) state_r <= DONE;
                end
                DONE: begin
                    if (out_free_s) begin
                        ex_valid_r <= 1'b1;
                        out_r      <= mdu_result_s;
                        uop_out_r  <= uop_lat_r;
                        state_r    <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_exu_mdu.sv
// Self-checking bench for pipe_exu_mdu: directed literal cases plus randomized traffic
// against a cycle-level behavioural model of the stage.
module tb_pipe_exu_mdu;
    import liang::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_i;
    logic            flush_i;
    uop_info_t       uop_info_i;
    logic [XLEN-1:0] rs1_rdata_i;
    logic [XLEN-1:0] rs2_rdata_i;
    logic            id_valid_i;
    logic            ex_ready_o;
    uop_info_t       uop_info_o;
    logic [XLEN-1:0] exu_output_o;
    logic            ex_valid_o;
    logic            wb_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    // behavioural model state
    logic        m_valid;
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_out;
    logic [31:0] m_res;
    uop_info_t   m_ouop;
    uop_info_t   m_puop;

    pipe_exu_mdu #(.XLEN(XLEN), .MDU_EN(1)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .uop_info_i   (uop_info_i),
        .rs1_rdata_i  (rs1_rdata_i),
        .rs2_rdata_i  (rs2_rdata_i),
        .id_valid_i   (id_valid_i),
        .ex_ready_o   (ex_ready_o),
        .uop_info_o   (uop_info_o),
        .exu_output_o (exu_output_o),
        .ex_valid_o   (ex_valid_o),
        .wb_ready_i   (wb_ready_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input exu_op_e op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        p  = {32'd0, a} * {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            EXU_ADD:   return a + b;
            EXU_SUB:   return a - b;
            EXU_AND:   return a & b;
            EXU_OR:    return a | b;
            EXU_XOR:   return a ^ b;
            EXU_SLL:   return a << b[4:0];
            EXU_SRL:   return a >> b[4:0];
            EXU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            EXU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            EXU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            EXU_MUL:   return p[31:0];
            EXU_MULHU: return p[63:32];
            EXU_DIV:   return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            EXU_REM:   return (b == 32'd0) ? a : 32'(sa % sb);
            EXU_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            EXU_REMU:  return (b == 32'd0) ? a : a % b;
            default:   return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_pend  = 1'b0;
        m_cnt   = 0;
        m_out   = 32'd0;
        m_res   = 32'd0;
        m_ouop  = UOP_NONE;
        m_puop  = UOP_NONE;
    endtask

    // One clock: drive inputs, compare DUT to model, advance model, move to next negedge
    task automatic cycle(input logic vld, input exu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic wbr, input logic fl);
        uop_info_t u;
        logic      exp_ready;
        u.fu_op     = op;
        u.rd        = 5'($urandom_range(0, 31));
        u.rd_wen    = 1'($urandom_range(0, 1));
        id_valid_i  = vld;
        uop_info_i  = u;
        rs1_rdata_i = a;
        rs2_rdata_i = b;
        wb_ready_i  = wbr;
        flush_i     = fl;
        #1;
        exp_ready = !m_pend && !fl && (!m_valid || wbr);
        check("ex_ready", 64'(ex_ready_o), 64'(exp_ready));
        check("ex_valid", 64'(ex_valid_o), 64'(m_valid));
        if (m_valid) begin
            check("exu_output", 64'(exu_output_o), 64'(m_out));
            check("uop_info", 64'(uop_info_o), 64'(m_ouop));
        end
        if (fl) begin
            m_valid = 1'b0;
            m_pend  = 1'b0;
        end else begin
            if (m_valid && wbr) m_valid = 1'b0;
            if (vld && exp_ready) begin
                if (is_mdu_op(op)) begin
                    m_pend = 1'b1;
                    m_cnt  = XLEN;
                    m_res  = ref_result(op, a, b);
                    m_puop = u;
                end else begin
                    m_valid = 1'b1;
                    m_out   = ref_result(op, a, b);
                    m_ouop  = u;
                end
            end else if (m_pend) begin
                if (m_cnt != 0) begin
                    m_cnt--;
                end else if (!m_valid) begin
                    m_valid = 1'b1;
                    m_out   = m_res;
                    m_ouop  = m_puop;
                    m_pend  = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, EXU_ADD, 32'd0, 32'd0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    exu_op_e     mdu_ops [10] = '{EXU_MUL, EXU_MULHU, EXU_DIV, EXU_REM, EXU_DIVU, EXU_REMU,
                                  EXU_DIV, EXU_REM, EXU_DIV, EXU_REM};
    logic [31:0] mdu_a   [10] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] mdu_b   [10] = '{32'd3, 32'd3, 32'd2, 32'd2, 32'd7, 32'd7,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] mdu_exp [10] = '{32'hFFFF_FFFD, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    exu_op_e     b2b_ops [4] = '{EXU_ADD, EXU_SUB, EXU_XOR, EXU_SLTU};
    logic [31:0] b2b_a   [4] = '{32'd5, 32'd10, 32'h0000_00F0, 32'd1};
    logic [31:0] b2b_b   [4] = '{32'd7, 32'd3, 32'h0000_00FF, 32'd2};
    logic [31:0] b2b_exp [4] = '{32'd12, 32'd7, 32'h0000_000F, 32'd1};

    initial begin
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        id_valid_i  = 1'b0;
        wb_ready_i  = 1'b1;
        uop_info_i  = UOP_NONE;
        rs1_rdata_i = 32'd0;
        rs2_rdata_i = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset ex_valid", 64'(ex_valid_o), 64'd0);
        check("reset exu_output", 64'(exu_output_o), 64'd0);
        check("reset uop_info", 64'(uop_info_o), 64'd0);
        check("reset ex_ready", 64'(ex_ready_o), 64'd1);
        rst_i = 1'b0;

        // back-to-back ALU ops, one result per cycle
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, b2b_ops[i], b2b_a[i], b2b_b[i], 1'b1, 1'b0);
            check("b2b valid", 64'(ex_valid_o), 64'd1);
            check("b2b result", 64'(exu_output_o), 64'(b2b_exp[i]));
        end
        idle(2);

        // SRA held under WB stall
        cycle(1'b1, EXU_SRA, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
        check("sra result", 64'(exu_output_o), 64'hF800_0000);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, EXU_ADD, 32'd1, 32'd1, 1'b0, 1'b0);
            check("stall hold", 64'(exu_output_o), 64'hF800_0000);
            check("stall ready", 64'(ex_ready_o), 64'd0);
        end
        cycle(1'b0, EXU_ADD, 32'd0, 32'd0, 1'b1, 1'b0);
        check("stall release", 64'(ex_valid_o), 64'd0);

        // MDU results and exact latency
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, mdu_ops[i], mdu_a[i], mdu_b[i], 1'b1, 1'b0);
            idle(32);
            check("mdu early", 64'(ex_valid_o), 64'd0);
            idle(1);
            check("mdu valid", 64'(ex_valid_o), 64'd1);
            check("mdu result", 64'(exu_output_o), 64'(mdu_exp[i]));
            idle(1);
        end

        // flush during BUSY
        cycle(1'b1, EXU_DIV, 32'd100, 32'd7, 1'b1, 1'b0);
        idle(10);
        cycle(1'b0, EXU_ADD, 32'd0, 32'd0, 1'b1, 1'b1);
        flush_i = 1'b0;
        #1;
        check("flush ready", 64'(ex_ready_o), 64'd1);
        check("flush valid", 64'(ex_valid_o), 64'd0);
        cycle(1'b1, EXU_ADD, 32'd20, 32'd22, 1'b1, 1'b0);
        check("post flush add", 64'(exu_output_o), 64'd42);
        idle(40);

        // asynchronous reset during BUSY
        cycle(1'b1, EXU_MUL, 32'd1234, 32'd5678, 1'b1, 1'b0);
        idle(5);
        #2;
        rst_i = 1'b1;
        #1;
        check("async rst valid", 64'(ex_valid_o), 64'd0);
        check("async rst output", 64'(exu_output_o), 64'd0);
        check("async rst uop", 64'(uop_info_o), 64'd0);
        check("async rst ready", 64'(ex_ready_o), 64'd1);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        idle(40);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            exu_op_e op;
            if ($urandom_range(0, 3) == 0) op = mdu_ops[$urandom_range(0, 5)];
            else                           op = exu_op_e'(5'($urandom_range(0, 9)));
            cycle(($urandom_range(0, 9) < 7), op, rnd_operand(), rnd_operand(),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        idle(40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_exu_mdu.md
# pipe_exu_mdu

Parametrised execute stage that sits between decode and writeback, with valid/ready handshakes on both sides. Single-cycle integer ALU ops flow through at one per cycle. Multiply and divide ops run on an iterative radix-2 unit that stalls the stage for XLEN cycles. A flush input squashes in-flight work.

## Interface
- XLEN, 32: datapath width; power of two, ≥8.
- MDU_EN, 1: 0 removes the iterative unit; MDU ops then complete as ALU ops with result 0.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  squash in-flight op and output register.
- uop_info_i  in  uop_info_t  decoded uop; op select is field fu_op (exu_op_e).
- rs1_rdata_i  in  XLEN  operand A.
- rs2_rdata_i  in  XLEN  operand B.
- id_valid_i  in  1  uop valid from ID.
- ex_ready_o  out  1  stage accepts a uop this cycle.
- uop_info_o  out  uop_info_t  uop carried to WB.
- exu_output_o  out  XLEN  result.
- ex_valid_o  out  1  result valid to WB.
- wb_ready_i  in  1  WB accepts result.

## Operation
- ALU ops: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU.
  - Shift amount is rs2[$clog2(XLEN)-1:0].
- MDU ops:
  - MUL: low XLEN bits of the product.
  - MULHU: high XLEN bits of the unsigned product.
  - DIV, DIVU, REM, REMU.
- Handshake:
  - Accept = id_valid_i && ex_ready_o.
  - Result is transferred when ex_valid_o && wb_ready_i.
- ex_ready_o = (state==IDLE) && !flush_i && (!ex_valid_o || wb_ready_i).
- FSM states IDLE, BUSY, DONE:
  - IDLE, accept ALU op: load the output register; stay in IDLE.
  - IDLE, accept MDU op: latch operands and uop; cnt=0; go to BUSY.
  - BUSY: one shift-add (MUL/MULHU) or restoring-subtract step (DIV/REM) per cycle; cnt++. At cnt==XLEN-1, go to DONE.
  - DONE: write result and latched uop into the output register when it is empty or draining this cycle; go to IDLE. Otherwise hold in DONE.
- Signed DIV/REM:
  - Operands are converted to magnitudes on entry.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Divide by zero: quotient all-ones; remainder = dividend.
- DIV overflow (dividend = min negative, divisor = -1): quotient = dividend; remainder = 0.
- Special cases keep the full MDU latency; the result is overridden in DONE.
- Width rules:
  - Multiplier accumulator is 2·XLEN bits.
  - Divider partial remainder is XLEN+1 bits.
  - cnt is $clog2(XLEN) bits.
- Flush, in any state:
  - Next cycle: state=IDLE, ex_valid_o=0, latched op discarded.
  - A uop presented during the flush cycle is not accepted.
- Flush has priority over simultaneous accept and over WB transfer.

## Timing
- Reset values: ex_valid_o=0, uop_info_o='0, exu_output_o='0, state=IDLE, cnt=0. ex_ready_o=1 after reset.
- ALU latency 1: accepted in cycle N, ex_valid_o=1 in N+1.
- Back-to-back ALU ops sustain one per cycle while wb_ready_i=1.
- MDU latency XLEN+2: accepted in N; BUSY N+1..N+XLEN; DONE N+XLEN+1; ex_valid_o=1 in N+XLEN+2.
- ex_ready_o=0 from N+1 until the cycle after DONE writes the output register.
- WB stall (ex_valid_o=1, wb_ready_i=0): uop_info_o and exu_output_o hold stable; ex_ready_o=0; a finished MDU op waits in DONE.
- Reset asserted mid-BUSY: all state returns to reset values immediately (asynchronous); no result is ever emitted.

## Structure
- Package liang gains:
  - exu_op_e enum: ALU and MDU members; MDU ops identified by the encoding MSB.
  - fu_op field in uop_info_t.
  - ele_t remains logic[31:0], the XLEN=32 default; ports use logic[XLEN-1:0].
- Sub-module pipe_exu_mdu_iter, parametrised by XLEN:
  - Implements the iterative mul/div datapath, cnt, and sign/special-case fixup.
  - Interface: start, op, a, b, flush → done, result.
- FSM, ALU and output register live in the top.
- MDU_EN=0 does not instantiate pipe_exu_mdu_iter.

## Test plan
- ADD 5+7, wb_ready_i=1 → exu_output_o=12 one cycle after accept. Four back-to-back ALU ops → four consecutive valid cycles.
- SRA 0x80000000 by 4 accepted, wb_ready_i held 0 for 3 cycles → output stays 0xF8000000 with ex_ready_o=0; transfer on release.
- MUL 0xFFFFFFFF×3 → 0xFFFFFFFD. MULHU on the same operands → 0x00000002, with ex_valid_o in cycle N+34.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; REM 0x80000000/-1 → 0.
- flush_i pulsed at BUSY cycle 10 → no ex_valid_o, ex_ready_o=1 next cycle, next ADD correct. Reset at BUSY cycle 5 → all outputs at reset values at once.
